// File: rtl/fsm_step_sequencer_if.sv
// Host and target-side signal bundle for fsm_step_sequencer.
// slave = sequencer view; master = host/bench view (also supplies the target's state/out).
interface fsm_step_sequencer_if #(
    parameter int DEPTH = 16,
    parameter int SW_W  = 2,
    parameter int ST_W  = 3
) ();
    localparam int AW = $clog2(DEPTH);
    localparam int E  = 1 + ST_W + SW_W;

    logic              prog_we;
    logic [AW-1:0]     prog_addr;
    logic [E-1:0]      prog_data;
    logic [AW:0]       num_steps;
    logic [ST_W-1:0]   init_state;
    logic              start;
    logic              busy;
    logic              done;
    logic              pass;
    logic [AW:0]       mismatch_cnt;
    logic              first_fail_valid;
    logic [AW-1:0]     first_fail_idx;
    logic              dut_reset;
    logic [ST_W-1:0]   dut_state_in;
    logic [SW_W-1:0]   dut_sw;
    logic              dut_ctrl;
    logic [ST_W-1:0]   dut_state;
    logic              dut_out;

    modport slave (
        input  prog_we, prog_addr, prog_data, num_steps, init_state, start,
        input  dut_state, dut_out,
        output busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_idx,
        output dut_reset, dut_state_in, dut_sw, dut_ctrl
    );

    modport master (
        output prog_we, prog_addr, prog_data, num_steps, init_state, start,
        output dut_state, dut_out,
        input  busy, done, pass, mismatch_cnt, first_fail_valid, first_fail_idx,
        input  dut_reset, dut_state_in, dut_sw, dut_ctrl
    );
endinterface

// File: rtl/fsm_step_sequencer.sv
// Loads a target FSM via its reset, steps it from a programmed table and checks state/out.
// Optional macro SEQ_STOP_ON_MISMATCH_EN: end the run at the first mismatching step.
module fsm_step_sequencer #(
    parameter int DEPTH  = 16,
    parameter int SW_W   = 2,
    parameter int ST_W   = 3,
    parameter int SETTLE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    fsm_step_sequencer_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int E  = 1 + ST_W + SW_W;
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT   = (AW+1)'(1);
    localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_FIN
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     w_idx_next;
    logic [3:0]        r_wait;
    logic [AW:0]       r_num;
    logic [ST_W-1:0]   r_init;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [AW:0]       r_cnt;
    logic [AW:0]       w_cnt_next;
    logic              r_ffv;
    logic [AW-1:0]     r_ffi;
    logic              r_dut_reset;
    logic              r_dut_ctrl;
    logic              r_in_step;
    logic              w_start_acc;
    logic              w_mismatch;
    logic              w_stop;
    logic              w_last;

    logic [E-1:0]      r_mem [DEPTH];
    logic [E-1:0]      r_entry;

    logic              w_exp_out;
    logic [ST_W-1:0]   w_exp_state;
    logic [SW_W-1:0]   w_entry_sw;

    assign w_exp_out   = r_entry[E-1];
    assign w_exp_state = r_entry[SW_W +: ST_W];
    assign w_entry_sw  = r_entry[SW_W-1:0];

    // Table has no reset so its contents survive an aborted run.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && bus.prog_we) begin
            r_mem[bus.prog_addr] <= bus.prog_data;
        end
        r_entry <= r_mem[w_idx_next];
    end

    assign w_mismatch = (r_state == S_CHECK) &&
                        ((bus.dut_state != w_exp_state) || (bus.dut_out != w_exp_out));
    assign w_last     = (({1'b0, r_idx} + ONE_CNT) >= r_num);

`ifdef SEQ_STOP_ON_MISMATCH_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_start_acc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_acc  = 1'b1;
                    w_idx_next   = '0;
                    w_state_next = (bus.num_steps == '0) ? S_FIN : S_LOAD;
                end
            end
            S_LOAD:  w_state_next = S_GAP;
            S_GAP:   w_state_next = S_DRIVE;
            S_DRIVE: w_state_next = (SETTLE == 0) ? S_CHECK : S_WAIT;
            S_WAIT: begin
                if (r_wait == SETTLE_M1) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (w_stop || w_last) begin
                    w_state_next = S_FIN;
                end else begin
                    w_state_next = S_DRIVE;
                    w_idx_next   = r_idx + 1'b1;
                end
            end
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_start_acc) begin
            w_cnt_next = '0;
        end else if (w_mismatch && (r_cnt != DEPTH_CNT)) begin
            w_cnt_next = r_cnt + ONE_CNT;
        end
    end

    // Outputs are registered from the next state so the target sees glitch-free reset/ctrl.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_wait      <= '0;
            r_num       <= '0;
            r_init      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_cnt       <= '0;
            r_ffv       <= 1'b0;
            r_ffi       <= '0;
            r_dut_reset <= 1'b1;
            r_dut_ctrl  <= 1'b0;
            r_in_step   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_wait      <= (r_state == S_WAIT && w_state_next == S_WAIT) ? r_wait + 4'd1 : 4'd0;
            r_busy      <= (w_state_next != S_IDLE) && (w_state_next != S_FIN);
            r_done      <= (w_state_next == S_FIN);
            r_dut_reset <= (w_state_next == S_LOAD);
            r_dut_ctrl  <= (w_state_next == S_DRIVE);
            r_in_step   <= (w_state_next == S_DRIVE) || (w_state_next == S_WAIT) ||
                           (w_state_next == S_CHECK);
            r_cnt       <= w_cnt_next;

            if (w_start_acc) begin
                r_num  <= bus.num_steps;
                r_init <= bus.init_state;
                r_ffv  <= 1'b0;
                r_ffi  <= '0;
                r_pass <= 1'b0;
            end
            if (w_mismatch && !r_ffv) begin
                r_ffv <= 1'b1;
                r_ffi <= r_idx;
            end
            if (w_state_next == S_FIN && r_state != S_FIN) begin
                r_pass <= (w_cnt_next == '0);
            end
        end
    end

    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.pass             = r_pass;
    assign bus.mismatch_cnt     = r_cnt;
    assign bus.first_fail_valid = r_ffv;
    assign bus.first_fail_idx   = r_ffi;
    assign bus.dut_reset        = r_dut_reset;
    assign bus.dut_state_in     = r_init;
    assign bus.dut_sw           = r_in_step ? w_entry_sw : '0;
    assign bus.dut_ctrl         = r_dut_ctrl;
endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Directed bench for fsm_step_sequencer: a 2-state target model (optionally faulty)
// on a SETTLE=1 instance, plus a SETTLE=0, DEPTH=4 instance against a stuck target.
module tb_fsm_step_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    fsm_step_sequencer_if #(.DEPTH(16), .SW_W(2), .ST_W(3)) if1 ();
    fsm_step_sequencer_if #(.DEPTH(4),  .SW_W(2), .ST_W(3)) if2 ();

    fsm_step_sequencer #(.DEPTH(16), .SW_W(2), .ST_W(3), .SETTLE(1)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (if1)
    );

    fsm_step_sequencer #(.DEPTH(4), .SW_W(2), .ST_W(3), .SETTLE(0)) u_dut_s0 (
        .clk   (clk),
        .reset (rst),
        .bus   (if2)
    );

    // Target: on ctrl with sw!=0, 0->1 (faulty: 0->3), any nonzero->0; out = (state==0).
    logic [2:0] tgt_state;
    bit         faulty = 1'b0;
    always @(posedge clk or posedge if1.dut_reset) begin
        if (if1.dut_reset)
            tgt_state <= if1.dut_state_in;
        else if (if1.dut_ctrl && (if1.dut_sw != 2'd0))
            tgt_state <= (tgt_state == 3'd0) ? (faulty ? 3'd3 : 3'd1) : 3'd0;
    end
    assign if1.dut_state = tgt_state;
    assign if1.dut_out   = (tgt_state == 3'd0);

    // Second target is stuck so every step mismatches.
    assign if2.dut_state = 3'd5;
    assign if2.dut_out   = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic prog1(input int addr, input logic [5:0] data);
        @(negedge clk);
        if1.prog_we   = 1'b1;
        if1.prog_addr = 4'(addr);
        if1.prog_data = data;
        @(posedge clk);
        #1 if1.prog_we = 1'b0;
    endtask

    // Latency k = number of rising edges from the start edge to the cycle where done is seen.
    task automatic do_run(input int n, input logic [2:0] init,
                          output int lat, output int nctrl, output int fctrl, output int nrst);
        @(negedge clk);
        if1.num_steps  = 5'(n);
        if1.init_state = init;
        if1.start      = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        lat = 0; nctrl = 0; fctrl = 0; nrst = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (if1.dut_ctrl) begin
                nctrl++;
                if (fctrl == 0) fctrl = k;
            end
            if (if1.dut_reset) nrst++;
            if (if1.done) begin
                lat = k;
                break;
            end
        end
        $display("run n=%0d init=%0d: lat=%0d ctrl=%0d rst=%0d cnt=%0d pass=%0d",
                 n, init, lat, nctrl, nrst, if1.mismatch_cnt, if1.pass);
    endtask

    int lat, nctrl, fctrl, nrst;
    bit saw_done;

    initial begin
        if1.prog_we = 0; if1.prog_addr = 0; if1.prog_data = 0;
        if1.num_steps = 0; if1.init_state = 0; if1.start = 0;
        if2.prog_we = 0; if2.prog_addr = 0; if2.prog_data = 0;
        if2.num_steps = 0; if2.init_state = 0; if2.start = 0;

        repeat (2) @(negedge clk);
        chk("rst_busy",      32'(if1.busy), 0);
        chk("rst_done",      32'(if1.done), 0);
        chk("rst_pass",      32'(if1.pass), 0);
        chk("rst_cnt",       32'(if1.mismatch_cnt), 0);
        chk("rst_ffv",       32'(if1.first_fail_valid), 0);
        chk("rst_ffi",       32'(if1.first_fail_idx), 0);
        chk("rst_dut_reset", 32'(if1.dut_reset), 1);
        chk("rst_state_in",  32'(if1.dut_state_in), 0);
        chk("rst_sw",        32'(if1.dut_sw), 0);
        chk("rst_ctrl",      32'(if1.dut_ctrl), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_dut_reset", 32'(if1.dut_reset), 0);

        // {exp_out, exp_state, sw}
        prog1(0, {1'b0, 3'd1, 2'd1});
        prog1(1, {1'b0, 3'd1, 2'd0});
        prog1(2, {1'b1, 3'd0, 2'd1});

        // Passing run: 3 + 3*(2+1) = 12
        do_run(3, 3'd0, lat, nctrl, fctrl, nrst);
        chk("pass_lat",   32'(lat), 12);
        chk("pass_pass",  32'(if1.pass), 1);
        chk("pass_cnt",   32'(if1.mismatch_cnt), 0);
        chk("pass_ffv",   32'(if1.first_fail_valid), 0);
        chk("pass_nctrl", 32'(nctrl), 3);
        chk("pass_fctrl", 32'(fctrl), 3);
        chk("pass_nrst",  32'(nrst), 1);
        chk("pass_busy_at_done", 32'(if1.busy), 0);

        // start + prog_we mid-run must be ignored
        @(negedge clk);
        if1.num_steps = 5'd3; if1.init_state = 3'd0; if1.start = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 4) begin
                if1.start = 1'b1; if1.num_steps = 5'd0;
                if1.prog_we = 1'b1; if1.prog_addr = 4'd0; if1.prog_data = 6'h3F;
            end else if (k == 5) begin
                if1.start = 1'b0; if1.prog_we = 1'b0;
            end
            if (if1.done) begin
                lat = k;
                break;
            end
        end
        $display("disturbed run: lat=%0d cnt=%0d pass=%0d", lat, if1.mismatch_cnt, if1.pass);
        chk("dist_lat",  32'(lat), 12);
        chk("dist_pass", 32'(if1.pass), 1);
        chk("dist_cnt",  32'(if1.mismatch_cnt), 0);
        do_run(3, 3'd0, lat, nctrl, fctrl, nrst);
        chk("table_kept_pass", 32'(if1.pass), 1);

        // Empty run
        do_run(0, 3'd0, lat, nctrl, fctrl, nrst);
        chk("empty_lat",   32'(lat), 1);
        chk("empty_pass",  32'(if1.pass), 1);
        chk("empty_nrst",  32'(nrst), 0);
        chk("empty_nctrl", 32'(nctrl), 0);

        // Faulty target: 0->3 on step 0, stays 3 on step 1, 3->0 matches on step 2
        faulty = 1'b1;
        do_run(3, 3'd0, lat, nctrl, fctrl, nrst);
        chk("fault_pass", 32'(if1.pass), 0);
        chk("fault_ffv",  32'(if1.first_fail_valid), 1);
        chk("fault_ffi",  32'(if1.first_fail_idx), 0);
`ifdef SEQ_STOP_ON_MISMATCH_EN
        chk("fault_lat",   32'(lat), 6);
        chk("fault_cnt",   32'(if1.mismatch_cnt), 1);
        chk("fault_nctrl", 32'(nctrl), 1);
`else
        chk("fault_lat",   32'(lat), 12);
        chk("fault_cnt",   32'(if1.mismatch_cnt), 2);
        chk("fault_nctrl", 32'(nctrl), 3);
`endif
        faulty = 1'b0;

        // Reset during WAIT of step 1 (cycle T+7)
        @(negedge clk);
        if1.num_steps = 5'd3; if1.init_state = 3'd0; if1.start = 1'b1;
        @(posedge clk);
        #1 if1.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy",      32'(if1.busy), 0);
        chk("abort_dut_reset", 32'(if1.dut_reset), 1);
        chk("abort_cnt",       32'(if1.mismatch_cnt), 0);
        chk("abort_ctrl",      32'(if1.dut_ctrl), 0);
        saw_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (if1.done) saw_done = 1'b1;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (if1.done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 0);
        do_run(3, 3'd0, lat, nctrl, fctrl, nrst);
        chk("after_abort_lat",  32'(lat), 12);
        chk("after_abort_pass", 32'(if1.pass), 1);

        // SETTLE=0, DEPTH=4, every step wrong: 3 + 2*4 = 11
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            if2.prog_we = 1'b1; if2.prog_addr = 2'(a); if2.prog_data = 6'd0;
            @(posedge clk);
            #1 if2.prog_we = 1'b0;
        end
        @(negedge clk);
        if2.num_steps = 3'd4; if2.start = 1'b1;
        @(posedge clk);
        #1 if2.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (if2.done) begin
                lat = k;
                break;
            end
        end
        $display("settle0 run: lat=%0d cnt=%0d ffi=%0d pass=%0d",
                 lat, if2.mismatch_cnt, if2.first_fail_idx, if2.pass);
        chk("s0_lat",  32'(lat), 11);
        chk("s0_cnt",  32'(if2.mismatch_cnt), 4);
        chk("s0_ffi",  32'(if2.first_fail_idx), 0);
        chk("s0_ffv",  32'(if2.first_fail_valid), 1);
        chk("s0_pass", 32'(if2.pass), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
